// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared handshake widths, transmitter state type and length decode
package hs_pkg;

  localparam int HS_DATA_W = 7;
  localparam int HS_LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } hs_tx_state_t;

  // A zero length field encodes the longest burst (16 beats).
  function automatic logic [HS_LEN_W:0] hs_len_decode(input logic [HS_LEN_W-1:0] len);
    return (len == '0) ? {1'b1, {HS_LEN_W{1'b0}}} : {1'b0, len};
  endfunction

endpackage

// File: rtl/hs_burst_tx.sv
// rtl/hs_burst_tx.sv - burst transmitter: one command in, incrementing word stream out
module hs_burst_tx
  import hs_pkg::HS_DATA_W;
  import hs_pkg::HS_LEN_W;
  import hs_pkg::hs_tx_state_t;
  import hs_pkg::hs_len_decode;
#(
  parameter int GAP     = 0,
  parameter int STALL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [HS_DATA_W-1:0] cmd_base,
  input  logic [HS_LEN_W-1:0]  cmd_len,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [HS_DATA_W-1:0] data_o,
  output logic                 last_o,
  output logic                 busy,
  output logic [STALL_W-1:0]   stall_cnt
);

  hs_tx_state_t         state_q, state_d;
  logic [HS_DATA_W-1:0] word_q,  word_d;
  logic [HS_LEN_W:0]    rem_q,   rem_d;
  logic [3:0]           gap_q,   gap_d;
  logic [STALL_W-1:0]   stall_q, stall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= hs_pkg::IDLE;
      word_q  <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    stall_d = stall_q;
    unique case (state_q)
      hs_pkg::IDLE: begin
        if (cmd_valid) begin
          word_d  = cmd_base;
          rem_d   = hs_len_decode(cmd_len);
          stall_d = '0;
          state_d = hs_pkg::SEND;
        end
      end
      hs_pkg::SEND: begin
        if (ready_i) begin
          rem_d = rem_q - (HS_LEN_W+1)'(1);
          if (rem_q == (HS_LEN_W+1)'(1)) begin
            state_d = hs_pkg::IDLE;
          end else begin
            word_d = word_q + HS_DATA_W'(1);
            // Gap counter counts the low cycles still to go, so GAP cycles exactly.
            if (GAP > 0) begin
              state_d = hs_pkg::GAP;
              gap_d   = 4'(GAP);
            end
          end
        end else if (stall_q != '1) begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      hs_pkg::GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d   = '0;
          state_d = hs_pkg::SEND;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = hs_pkg::IDLE;
    endcase
  end

  // Every handshake output is decoded from registers only; nothing sees ready_i or cmd_valid.
  always_comb begin
    cmd_ready = (state_q == hs_pkg::IDLE);
    busy      = (state_q != hs_pkg::IDLE);
    valid_o   = (state_q == hs_pkg::SEND);
    last_o    = (state_q == hs_pkg::SEND) && (rem_q == (HS_LEN_W+1)'(1));
    data_o    = word_q;
    stall_cnt = stall_q;
  end

endmodule

// File: tb/tb_hs_burst_tx.sv
// tb/tb_hs_burst_tx.sv - randomized bench for hs_burst_tx with GAP=0 and GAP=2 instances
module tb_hs_burst_tx;

  localparam int G1 = 2;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [6:0] cmd_base;
  logic [3:0] cmd_len;
  logic       ready_i;
  logic [1:0] cmd_ready;
  logic [1:0] valid_o;
  logic [1:0] last_o;
  logic [1:0] busy;
  logic [6:0] data_o [2];
  logic [7:0] stall_cnt [2];

  int checks = 0;
  int errors = 0;

  int m_left  [2];
  int m_gap   [2];
  int m_word  [2];
  int m_stall [2];

  hs_burst_tx #(.GAP(0), .STALL_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .valid_o(valid_o[0]), .ready_i(ready_i),
    .data_o(data_o[0]), .last_o(last_o[0]), .busy(busy[0]), .stall_cnt(stall_cnt[0])
  );

  hs_burst_tx #(.GAP(G1), .STALL_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .valid_o(valid_o[1]), .ready_i(ready_i),
    .data_o(data_o[1]), .last_o(last_o[1]), .busy(busy[1]), .stall_cnt(stall_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Burst-level reference: words left, idle cycles left, current word, stall count.
  task automatic model_edge(input int k, input bit r, input bit cv, input int base,
                            input int len, input bit rdy);
    int g;
    g = (k == 1) ? G1 : 0;
    if (r) begin
      m_left[k] = 0; m_gap[k] = 0; m_word[k] = 0; m_stall[k] = 0;
    end else if (m_left[k] == 0) begin
      if (cv) begin
        m_word[k]  = base % 128;
        m_left[k]  = (len % 16 == 0) ? 16 : len % 16;
        m_gap[k]   = 0;
        m_stall[k] = 0;
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
    end else if (rdy) begin
      if (m_left[k] == 1) begin
        m_left[k] = 0;
      end else begin
        m_word[k] = (m_word[k] + 1) % 128;
        m_left[k]--;
        m_gap[k] = g;
      end
    end else if (m_stall[k] < 255) begin
      m_stall[k]++;
    end
  endtask

  task automatic compare(input int k);
    int ev;
    ev = (m_left[k] > 0 && m_gap[k] == 0) ? 1 : 0;
    check($sformatf("valid%0d", k), valid_o[k], ev);
    check($sformatf("cmd_ready%0d", k), cmd_ready[k], (m_left[k] == 0) ? 1 : 0);
    check($sformatf("busy%0d", k), busy[k], (m_left[k] > 0) ? 1 : 0);
    check($sformatf("last%0d", k), last_o[k], (ev == 1 && m_left[k] == 1) ? 1 : 0);
    check($sformatf("stall%0d", k), stall_cnt[k], m_stall[k]);
    if (ev == 1) check($sformatf("data%0d", k), data_o[k], m_word[k]);
  endtask

  task automatic step(input bit r, input bit cv, input int base, input int len, input bit rdy);
    rst       = r;
    cmd_valid = cv;
    cmd_base  = 7'(base);
    cmd_len   = 4'(len);
    ready_i   = rdy;
    for (int k = 0; k < 2; k++) model_edge(k, r, cv, base, len, rdy);
    @(negedge clk);
    for (int k = 0; k < 2; k++) compare(k);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy != 2'b00 && n < 200) begin
      step(0, 0, 0, 0, 1);
      n++;
    end
    check("drain_idle", busy, 0);
  endtask

  initial begin
    int pat;
    rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; ready_i = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 1, 33, 2, 1);
    check("rst_valid", valid_o, 0);
    check("rst_data0", data_o[0], 0);
    check("rst_last", last_o, 0);
    check("rst_cmd_ready", cmd_ready, 3);
    check("rst_busy", busy, 0);
    check("rst_stall0", stall_cnt[0], 0);

    // Three-beat burst from 5 with ready held high.
    step(0, 1, 5, 3, 1);
    check("t1_beat0", data_o[0], 5);
    step(0, 0, 0, 0, 1);
    check("t1_beat1", data_o[0], 6);
    step(0, 0, 0, 0, 1);
    check("t1_beat2", data_o[0], 7);
    check("t1_last", last_o[0], 1);
    step(0, 0, 0, 0, 1);
    check("t1_ready_after", cmd_ready[0], 1);
    drain();

    // Sixteen beats wrapping through 127 -> 0.
    step(0, 1, 126, 0, 1);
    for (int i = 1; i < 16; i++) step(0, 0, 0, 0, 1);
    check("t2_final_word", data_o[0], 13);
    check("t2_final_last", last_o[0], 1);
    drain();

    // Backpressure on beat 2 for three cycles.
    step(0, 1, 40, 4, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      check("t3_hold", data_o[0], 41);
    end
    drain();
    check("t3_stall", stall_cnt[0], 3);

    // GAP=2 valid pattern 1001001 over a 3-beat burst.
    pat = 0;
    step(0, 1, 20, 3, 1);
    pat = valid_o[1];
    for (int i = 1; i < 7; i++) begin
      step(0, 0, 0, 0, 1);
      pat = (pat << 1) | int'(valid_o[1]);
    end
    check("t4_gap_pattern", pat, 7'b1001001);
    step(0, 0, 0, 0, 1);
    check("t4_ready_after", cmd_ready[1], 1);
    drain();

    // Reset during beat 2, then a fresh burst.
    step(0, 1, 60, 4, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("t5_valid", valid_o[0], 0);
    check("t5_cmd_ready", cmd_ready[0], 1);
    check("t5_data", data_o[0], 0);
    step(0, 1, 100, 2, 1);
    check("t5_restart", data_o[0], 100);
    drain();

    // cmd_valid held high with alternating base.
    for (int i = 0; i < 80; i++)
      step(0, 1, (i % 2 == 1) ? 10 : 90, $urandom_range(1, 4), 1);
    drain();

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 127),
           $urandom_range(0, 15), $urandom_range(0, 9) < 7);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_burst_tx.md
# hs_burst_tx

Burst transmitter for the team's 7-bit valid/ready handshake. It drives the producer side of the interface that the existing receiving pipeline consumes. The block accepts one burst command (base value, length), then emits an incrementing word sequence on `valid_o`/`data_o`, holds the word stable under backpressure, and flags the final beat. It sits upstream of the master/slave register chain as the test-traffic and DMA-style source.

## Interface
Parameters:
- `GAP`, default 0: idle cycles with `valid_o` low after each accepted non-last beat. Legal range is 0..15.
- `STALL_W`, default 8: width of the stall counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block can accept a command (IDLE only).
- `cmd_base`  in  7  first data word of the burst.
- `cmd_len`  in  4  beat count. 1..15 literal; 0 means 16.
- `valid_o`  out  1  `data_o` is valid toward the downstream stage.
- `ready_i`  in  1  downstream ready.
- `data_o`  out  7  current word.
- `last_o`  out  1  current word is the final beat; qualified by `valid_o`.
- `busy`  out  1  burst in progress (not IDLE).
- `stall_cnt`  out  `STALL_W`  count of cycles in the current or most recent burst with `valid_o & !ready_i`.

## Operation
- States are IDLE, SEND and GAP.
- Command handshake: a command is accepted on a clock edge where `cmd_valid & cmd_ready`.
  - Latch `cmd_base` into the word register.
  - Load the remaining count from `cmd_len` (0 loads 16).
  - Clear `stall_cnt`.
  - Go to SEND.
- Beat transfer occurs on an edge where `valid_o & ready_i`.
- Transfer on a non-last beat:
  - Word register becomes `data_o + 1` mod 128; 127 wraps to 0.
  - Remaining count decrements.
  - Next state is GAP if `GAP > 0`, otherwise SEND.
- Transfer on the last beat (remaining count = 1): next state is IDLE.
- GAP state:
  - `valid_o` = 0.
  - A gap counter loads `GAP` on entry and decrements each cycle.
  - Return to SEND when it reaches 0, after exactly `GAP` cycles low.
- SEND state without transfer: hold everything. `data_o`, `last_o` and `valid_o` must not change while `valid_o & !ready_i`.
- `stall_cnt` increments on each SEND cycle with `!ready_i` and saturates at all-ones. It holds its value in IDLE until the next accepted command.
- Outputs decoded from state and registers:
  - `cmd_ready` = (state == IDLE).
  - `busy` = !IDLE.
  - `valid_o` = (state == SEND).
  - `last_o` = SEND & remaining == 1.
- Input changes: `cmd_valid` or `cmd_*` changes outside IDLE are ignored. `ready_i` may toggle arbitrarily.

## Timing
- Reset values: `valid_o` = 0, `data_o` = 0, `last_o` = 0, `cmd_ready` = 1, `busy` = 0, `stall_cnt` = 0, state IDLE.
- Reset mid-burst aborts in the same edge. No further beats are emitted.
- Command-to-first-beat latency: 1 cycle. `valid_o` rises on the cycle after command acceptance.
- With `GAP` = 0 and `ready_i` held high, a burst of N beats occupies N consecutive cycles.
- With `GAP` = G > 0 and `ready_i` held high, a burst of N beats occupies N + (N−1)·G cycles.
- After the last transfer, `cmd_ready` is high on the next cycle. Back-to-back bursts therefore have exactly 1 idle cycle between the last beat and the next command acceptance.
- `cmd_ready` is registered-state derived and has no combinational path from `cmd_valid`.
- `valid_o` is registered-state derived and never depends combinationally on `ready_i`. Valid must not wait for ready.
- A single-beat burst (`cmd_len` = 1) asserts `last_o` on its only beat and returns to IDLE after the transfer.

## Structure
- Shared package `hs_pkg` holds:
  - `HS_DATA_W` = 7 and `HS_LEN_W` = 4.
  - The state enum `hs_tx_state_t` {IDLE, SEND, GAP}.
  - The length decode function (0 → 16).
- The same package is used by the receiving pipeline for data width.
- Single module; no sub-module is warranted.
- Registers:
  - state
  - 7-bit word
  - 5-bit remaining count
  - 4-bit gap counter
  - stall counter

## Test plan
- Reset, then `cmd_base` = 5, `cmd_len` = 3, `ready_i` = 1, GAP = 0: `data_o` is 5, 6, 7 on 3 consecutive cycles; `last_o` is asserted only with 7; `cmd_ready` = 1 on the following cycle.
- `cmd_base` = 126, `cmd_len` = 0: 16 beats are emitted, 126, 127, 0, 1 … 13, demonstrating the wrap.
- `cmd_len` = 4 with `ready_i` low for 3 cycles on beat 2: `data_o` is held for those cycles, no beat is skipped or duplicated, and `stall_cnt` = 3 at the end.
- GAP = 2, `cmd_len` = 3, `ready_i` = 1: the `valid_o` pattern is 1, 0, 0, 1, 0, 0, 1, for a burst of 7 cycles.
- Assert `rst` during beat 2 of a 4-beat burst: on the next cycle `valid_o` = 0, `cmd_ready` = 1, and `data_o` = 0. A new command then starts correctly.
- Hold `cmd_valid` = 1 continuously with alternating `cmd_base`: commands are accepted only in IDLE, and mid-burst base changes have no effect on `data_o`.
